// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the single-cycle MIPS core: word RAM plus an MMIO page
// holding a cycle counter, compare timer with interrupt, GPIO register and a TX byte FIFO.
module mips_dmem_responder #(
    parameter int unsigned RAM_WORDS = 64,
    parameter int unsigned TX_DEPTH  = 4,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] gpio_out,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
    localparam int unsigned TX_AW     = $clog2(TX_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [TX_AW:0] TX_FULL = (TX_AW + 1)'(TX_DEPTH);

    localparam logic [5:0] OFF_CYCLE  = 6'h00;
    localparam logic [5:0] OFF_TCMP   = 6'h01;
    localparam logic [5:0] OFF_TCTRL  = 6'h02;
    localparam logic [5:0] OFF_TCNT   = 6'h03;
    localparam logic [5:0] OFF_GPIO   = 6'h04;
    localparam logic [5:0] OFF_TXDATA = 6'h05;
    localparam logic [5:0] OFF_TXSTAT = 6'h06;

    // Address decode
    logic              is_ram;
    logic              is_mmio;
    logic [5:0]        mmio_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_adr;

    assign is_ram     = dataadr < RAM_BYTES;
    assign is_mmio    = dataadr[31:8] == MMIO_BASE[31:8];
    assign mmio_off   = dataadr[7:2];
    assign ram_idx    = dataadr[RAM_AW+1:2];
    assign unused_adr = ^dataadr[1:0];

    logic mmio_wr;
    logic wr_ram, wr_tcmp, wr_tctrl, wr_tcnt, wr_gpio, wr_txdata, wr_txstat;

    assign mmio_wr   = memwrite & is_mmio;
    assign wr_ram    = memwrite & is_ram;
    assign wr_tcmp   = mmio_wr & (mmio_off == OFF_TCMP);
    assign wr_tctrl  = mmio_wr & (mmio_off == OFF_TCTRL);
    assign wr_tcnt   = mmio_wr & (mmio_off == OFF_TCNT);
    assign wr_gpio   = mmio_wr & (mmio_off == OFF_GPIO);
    assign wr_txdata = mmio_wr & (mmio_off == OFF_TXDATA);
    assign wr_txstat = mmio_wr & (mmio_off == OFF_TXSTAT);

    // Data RAM: no reset, contents survive reset
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[ram_idx] <= writedata;
        end
    end

    // Timer and counters
    logic [31:0] cycle_q, tcmp_q, tcnt_q, tcnt_d, gpio_q;
    logic        t_en_q, t_flag_q, t_flag_d, t_ar_q, t_ie_q;
    logic        t_match;

    assign t_match = tcnt_q == tcmp_q;

    always_comb begin
        tcnt_d   = tcnt_q;
        t_flag_d = t_flag_q;
        if (t_en_q) begin
            if (t_match) begin
                tcnt_d = t_ar_q ? 32'd0 : tcnt_q + 32'd1;
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end
        if (wr_tcnt) begin
            tcnt_d = writedata;
        end
        if (wr_tctrl && writedata[1]) begin
            t_flag_d = 1'b0;
        end
        // A hardware match wins over a simultaneous software clear
        if (t_en_q && t_match) begin
            t_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q  <= '0;
            tcmp_q   <= '0;
            tcnt_q   <= '0;
            gpio_q   <= '0;
            t_en_q   <= 1'b0;
            t_flag_q <= 1'b0;
            t_ar_q   <= 1'b0;
            t_ie_q   <= 1'b0;
        end else begin
            cycle_q  <= cycle_q + 32'd1;
            tcnt_q   <= tcnt_d;
            t_flag_q <= t_flag_d;
            if (wr_tcmp) begin
                tcmp_q <= writedata;
            end
            if (wr_gpio) begin
                gpio_q <= writedata;
            end
            if (wr_tctrl) begin
                t_en_q <= writedata[0];
                t_ar_q <= writedata[2];
                t_ie_q <= writedata[3];
            end
        end
    end

    assign gpio_out = gpio_q;
    assign irq      = t_flag_q & t_ie_q;

    // TX FIFO
    logic [7:0]       fifo [TX_DEPTH];
    logic [TX_AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
    logic             ovf_q, ovf_d;
    logic             pop, push_ok;

    assign tx_valid = tx_cnt_q != '0;
    assign pop      = tx_valid & tx_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still fits
    assign push_ok  = wr_txdata & ((tx_cnt_q < TX_FULL) | pop);
    assign tx_data  = tx_valid ? fifo[rd_ptr_q] : 8'h00;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        case ({push_ok, pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        ovf_d = ovf_q;
        if (wr_txstat && writedata[2]) begin
            ovf_d = 1'b0;
        end
        if (wr_txdata && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo[wr_ptr_q] <= writedata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            tx_cnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            ovf_q    <= ovf_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Read mux
    always_comb begin
        readdata = '0;
        if (is_ram) begin
            readdata = ram[ram_idx];
        end else if (is_mmio) begin
            case (mmio_off)
                OFF_CYCLE:  readdata = cycle_q;
                OFF_TCMP:   readdata = tcmp_q;
                OFF_TCTRL:  readdata = {28'h0, t_ie_q, t_ar_q, t_flag_q, t_en_q};
                OFF_TCNT:   readdata = tcnt_q;
                OFF_GPIO:   readdata = gpio_q;
                OFF_TXSTAT: readdata = {16'h0, 8'(tx_cnt_q), 5'h0, ovf_q, ~tx_valid,
                                        tx_cnt_q == TX_FULL};
                default:    readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench for mips_dmem_responder: RAM, MMIO registers, timer/irq,
// TX FIFO ordering/overflow and asynchronous reset, using read and TX scoreboards.
module tb_mips_dmem_responder;

    localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF00;
    localparam logic [31:0] A_TCMP   = 32'hFFFF_FF04;
    localparam logic [31:0] A_TCTRL  = 32'hFFFF_FF08;
    localparam logic [31:0] A_TCNT   = 32'hFFFF_FF0C;
    localparam logic [31:0] A_GPIO   = 32'hFFFF_FF10;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_FF14;
    localparam logic [31:0] A_TXSTAT = 32'hFFFF_FF18;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] readdata, gpio_out;
    logic        irq, tx_valid;
    logic [7:0]  tx_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_exp [$];
    logic [7:0]  tx_exp [$];
    logic [31:0] cyc_m;

    mips_dmem_responder #(
        .RAM_WORDS(64),
        .TX_DEPTH (4),
        .MMIO_BASE(32'hFFFF_FF00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memwrite (memwrite),
        .dataadr  (dataadr),
        .writedata(writedata),
        .readdata (readdata),
        .gpio_out (gpio_out),
        .irq      (irq),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    // Reference cycle count: one tick per rising edge out of reset
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc_m <= '0;
        else        cyc_m <= cyc_m + 32'd1;
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memwrite = 1'b1; dataadr = a; writedata = d;
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        memwrite = 1'b0; dataadr = a;
        #1 v = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] v, e;
        logic [31:0] addrs [4];
        addrs = '{A_TCNT, A_TCTRL, A_GPIO, A_TXSTAT};
        reset = 1'b0;
        #1;
        checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL reset_gpio: got %h expected 0", gpio_out); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h0) begin errors++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd_exp.push_back(32'h0); rd_exp.push_back(32'h0);
        rd_exp.push_back(32'h0); rd_exp.push_back(32'h2);
        for (int i = 0; i < 4; i++) begin
            load(addrs[i], v);
            e = rd_exp.pop_front();
            checks++;
            if (v !== e) begin errors++; $display("FAIL reset_reg%0d: got %h expected %h", i, v, e); end
        end
    endtask

    task automatic test_ram();
        logic [31:0] v, e, w;
        int idx;
        store(32'h0, 32'h0BAD_F00D);
        store(32'h10, 32'h1234_5678); rd_exp.push_back(32'h1234_5678);
        store(32'h100, 32'hCAFE_F00D); rd_exp.push_back(32'h0);
        rd_exp.push_back(32'h0BAD_F00D);
        for (int i = 0; i < 6; i++) begin
            idx = (i == 5) ? 63 : 8 + i;
            w = $urandom;
            store(32'(idx * 4), w);
            rd_exp.push_back(w);
        end
        load(32'h12, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL ram_lw_0x12: got %h expected %h", v, e); end
        load(32'h100, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL unmapped_lw_0x100: got %h expected %h", v, e); end
        load(32'h0, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL ram_word0_kept: got %h expected %h", v, e); end
        for (int i = 0; i < 6; i++) begin
            idx = (i == 5) ? 63 : 8 + i;
            load(32'(idx * 4), v); e = rd_exp.pop_front(); checks++;
            if (v !== e) begin errors++; $display("FAIL ram_word%0d: got %h expected %h", idx, v, e); end
        end
    endtask

    task automatic test_timer();
        logic e;
        store(A_TCMP, 32'd5);
        store(A_TCTRL, 32'hD);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            #1 e = (i == 6);
            checks++;
            if (irq !== e) begin errors++; $display("FAIL timer_irq_edge%0d: got %b expected %b", i, irq, e); end
        end
        dataadr = A_TCNT;
        #1 checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL timer_tcnt_reload: got %h expected 0", readdata); end
        dataadr = A_TCTRL;
        #1 checks++;
        if (readdata !== 32'hF) begin errors++; $display("FAIL timer_tctrl_read: got %h expected f", readdata); end
        store(A_TCTRL, 32'hF);
        #1 checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL timer_w1c: got %b expected 0", irq); end
        // Autoreload period is TCMP+1 edges: next match lands four edges later
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            #1 e = (i == 4);
            checks++;
            if (irq !== e) begin errors++; $display("FAIL timer_reload_irq%0d: got %b expected %b", i, irq, e); end
        end
        store(A_TCTRL, 32'h2);
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] v, e;
        logic [7:0]  b;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            store(A_TXDATA, 32'(8'hA1 + i));
            if (i < 4) tx_exp.push_back(8'(8'hA1 + i));
        end
        rd_exp.push_back(32'h0000_0405);
        load(A_TXSTAT, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL txstat_full_ovf: got %h expected %h", v, e); end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 b = tx_exp.pop_front();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== b)
                begin errors++; $display("FAIL tx_drain%0d: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, b); end
            @(negedge clk);
        end
        #1 checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained_valid: got %b expected 0", tx_valid); end
        tx_ready = 1'b0;
        rd_exp.push_back(32'h6);
        load(A_TXSTAT, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL txstat_empty: got %h expected %h", v, e); end
        store(A_TXSTAT, 32'h4);
        rd_exp.push_back(32'h2);
        load(A_TXSTAT, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL txstat_ovf_clear: got %h expected %h", v, e); end
    endtask

    task automatic test_fifo_full_push_pop();
        logic [31:0] v, e;
        logic [7:0]  b;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(A_TXDATA, 32'(8'hC1 + i));
            tx_exp.push_back(8'(8'hC1 + i));
        end
        @(negedge clk);
        tx_ready = 1'b1; memwrite = 1'b1; dataadr = A_TXDATA; writedata = 32'hB0;
        #1 b = tx_exp.pop_front();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== b)
            begin errors++; $display("FAIL fullpush_head: got v=%b d=%h expected v=1 d=%h", tx_valid, tx_data, b); end
        tx_exp.push_back(8'hB0);
        @(negedge clk);
        memwrite = 1'b0; tx_ready = 1'b0;
        rd_exp.push_back(32'h0000_0401);
        load(A_TXSTAT, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL fullpush_txstat: got %h expected %h", v, e); end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 b = tx_exp.pop_front();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== b)
                begin errors++; $display("FAIL fullpush_drain%0d: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, b); end
            @(negedge clk);
        end
        #1 checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL fullpush_empty: got %b expected 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_mmio_misc();
        logic [31:0] v, e;
        store(A_CYCLE, 32'h55);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            dataadr = A_CYCLE;
            #1 checks++;
            if (readdata !== cyc_m) begin errors++; $display("FAIL cycle_count%0d: got %h expected %h", i, readdata, cyc_m); end
        end
        store(A_GPIO, 32'hDEAD_BEEF);
        #1 checks++;
        if (gpio_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL gpio_out: got %h expected deadbeef", gpio_out); end
        store(A_TCMP, 32'h1234);
        rd_exp.push_back(32'hDEAD_BEEF); rd_exp.push_back(32'h0);
        rd_exp.push_back(32'h0); rd_exp.push_back(32'h0); rd_exp.push_back(32'h1234);
        load(A_GPIO, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL gpio_read: got %h expected %h", v, e); end
        load(A_TXDATA, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL txdata_read: got %h expected %h", v, e); end
        load(32'hFFFF_FF1C, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL mmio_hole_read: got %h expected %h", v, e); end
        load(32'h2000_0000, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL unmapped_read: got %h expected %h", v, e); end
        load(A_TCMP, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL tcmp_read: got %h expected %h", v, e); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] v, e;
        store(A_TCNT, 32'h0);
        store(A_TCMP, 32'h0);
        store(A_TCTRL, 32'h9);
        @(negedge clk);
        #1 checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL midrst_irq_pre: got %b expected 1", irq); end
        tx_ready = 1'b0;
        store(A_TXDATA, 32'h77);
        #1 checks++;
        if (tx_valid !== 1'b1) begin errors++; $display("FAIL midrst_txv_pre: got %b expected 1", tx_valid); end
        @(posedge clk);
        #2 reset = 1'b0;
        #1 checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b expected 0", irq); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_txv: got %b expected 0", tx_valid); end
        checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL midrst_gpio: got %h expected 0", gpio_out); end
        checks++; if (tx_data !== 8'h0) begin errors++; $display("FAIL midrst_txdata: got %h expected 0", tx_data); end
        tx_exp.delete();
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        dataadr = A_CYCLE;
        #1 checks++;
        if (readdata > 32'd1) begin errors++; $display("FAIL midrst_cycle: got %h expected 0..1", readdata); end
        rd_exp.push_back(32'h2); rd_exp.push_back(32'h0); rd_exp.push_back(32'h0);
        load(A_TXSTAT, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL midrst_txstat: got %h expected %h", v, e); end
        load(A_TCTRL, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL midrst_tctrl: got %h expected %h", v, e); end
        load(A_GPIO, v); e = rd_exp.pop_front(); checks++;
        if (v !== e) begin errors++; $display("FAIL midrst_gpio_read: got %h expected %h", v, e); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_timer();
        test_fifo_overflow();
        test_fifo_full_push_pop();
        test_mmio_misc();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
